mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 16:1 mux: steps sel through all channels, samples mux_out
// per channel and assembles a 16-bit word. Optional `MUX_SCAN_CONT_EN adds a `cont` input.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef MUX_SCAN_CONT_EN
  input  logic        cont,
`endif
  output logic [3:0]  sel,
  input  logic        mux_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] word
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] word_q, word_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    word_d   = word_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SETTLE;
          sel_d    = 4'd0;
          cnt_d    = 4'd0;
          shadow_d = 16'h0000;
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        shadow_d[sel_q] = mux_out;
        if (sel_q == 4'd15) begin
          // Bit 15 is taken straight from mux_out so word is complete on entry to DONE.
          word_d  = {mux_out, shadow_q[14:0]};
          state_d = S_DONE;
        end else begin
          sel_d   = sel_q + 4'd1;
          cnt_d   = 4'd0;
          state_d = S_SETTLE;
        end
      end

      S_DONE: begin
        sel_d   = 4'd0;
        state_d = S_IDLE;
`ifdef MUX_SCAN_CONT_EN
        if (cont) begin
          cnt_d    = 4'd0;
          shadow_d = 16'h0000;
          state_d  = S_SETTLE;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = 4'd0;
        cnt_d   = 4'd0;
      end
    endcase

    // Status flags are decoded from the next state so they are registered alongside it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= 4'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 16'h0000;
      word_q   <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign word = word_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench for mux_scan_ctrl: SETTLE=1 and SETTLE=3 instances,
// each fed by a behavioural 16:1 mux built from a stimulus vector.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start3;
  logic [15:0] vec1, vec3;
  logic [3:0]  sel1, sel3;
  logic        mux1, mux3;
  logic        busy1, busy3, done1, done3;
  logic [15:0] word1, word3;
`ifdef MUX_SCAN_CONT_EN
  logic        cont1;
  logic        cont3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mux1 = vec1[sel1];
  assign mux3 = vec3[sel3];

  mux_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start1),
`ifdef MUX_SCAN_CONT_EN
    .cont    (cont1),
`endif
    .sel     (sel1),
    .mux_out (mux1),
    .busy    (busy1),
    .done    (done1),
    .word    (word1)
  );

  mux_scan_ctrl #(.SETTLE(3)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start3),
`ifdef MUX_SCAN_CONT_EN
    .cont    (cont3),
`endif
    .sel     (sel3),
    .mux_out (mux3),
    .busy    (busy3),
    .done    (done3),
    .word    (word3)
  );

  // Advance n rising edges and settle just after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    vec1   = 16'h0000;
    vec3   = 16'h0000;
`ifdef MUX_SCAN_CONT_EN
    cont1  = 1'b0;
    cont3  = 1'b0;
`endif

    applyStimulus(2);
    checkOutput("rst_sel",  {12'h0, sel1},  16'h0);
    checkOutput("rst_busy", {15'h0, busy1}, 16'h0);
    checkOutput("rst_done", {15'h0, done1}, 16'h0);
    checkOutput("rst_word", word1,          16'h0000);
    checkOutput("rst_word3", word3,         16'h0000);
    rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("idle_busy", {15'h0, busy1}, 16'h0);

    // Basic scan, SETTLE=1: sel advances every 2 cycles, done at cycle 32.
    vec1   = 16'h3f0a;
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    checkOutput("acc_busy", {15'h0, busy1}, 16'h1);
    checkOutput("acc_sel",  {12'h0, sel1},  16'h0);
    for (int k = 1; k < 32; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("scan_sel_%0d", k), {12'h0, sel1}, 16'(k / 2));
      checkOutput($sformatf("scan_nodone_%0d", k), {15'h0, done1}, 16'h0);
    end
    applyStimulus(1);
    checkOutput("basic_done", {15'h0, done1}, 16'h1);
    checkOutput("basic_word", word1,          16'h3f0a);
    checkOutput("basic_sel15", {12'h0, sel1}, 16'hf);
    checkOutput("basic_busy_in_done", {15'h0, busy1}, 16'h1);
    applyStimulus(1);
    checkOutput("basic_done_low", {15'h0, done1}, 16'h0);
    checkOutput("basic_busy_low", {15'h0, busy1}, 16'h0);
    checkOutput("basic_sel0",     {12'h0, sel1},  16'h0);

    // start during a scan is ignored.
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    applyStimulus(12);
    checkOutput("hold_sel6", {12'h0, sel1}, 16'h6);
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    checkOutput("ignore_sel", {12'h0, sel1}, 16'h6);
    applyStimulus(19);
    checkOutput("ignore_done", {15'h0, done1}, 16'h1);
    checkOutput("ignore_word", word1,          16'h3f0a);
    applyStimulus(1);
    checkOutput("ignore_idle", {15'h0, busy1}, 16'h0);

    // word holds the old result until the next done.
    vec1   = 16'hc0f5;
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    applyStimulus(31);
    checkOutput("hold_word", word1,          16'h3f0a);
    checkOutput("hold_nodone", {15'h0, done1}, 16'h0);
    applyStimulus(1);
    checkOutput("new_done", {15'h0, done1}, 16'h1);
    checkOutput("new_word", word1,          16'hc0f5);
    applyStimulus(1);

    // Reset mid-scan at sel=12.
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    applyStimulus(24);
    checkOutput("mid_sel12", {12'h0, sel1}, 16'hc);
    rst_n = 1'b0;
    applyStimulus(1);
    rst_n = 1'b1;
    checkOutput("mid_busy", {15'h0, busy1}, 16'h0);
    checkOutput("mid_done", {15'h0, done1}, 16'h0);
    checkOutput("mid_word", word1,          16'h0000);
    checkOutput("mid_sel",  {12'h0, sel1},  16'h0);
    applyStimulus(8);
    checkOutput("mid_nodone", {15'h0, done1}, 16'h0);
    vec1   = 16'h1234;
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    applyStimulus(32);
    checkOutput("after_rst_done", {15'h0, done1}, 16'h1);
    checkOutput("after_rst_word", word1,          16'h1234);
    applyStimulus(1);

    // SETTLE=3: done at cycle 64, bit 0 and bit 15 boundaries.
    vec3   = 16'h8001;
    start3 = 1'b1;
    applyStimulus(1);
    start3 = 1'b0;
    applyStimulus(63);
    checkOutput("s3_nodone", {15'h0, done3}, 16'h0);
    checkOutput("s3_sel15",  {12'h0, sel3},  16'hf);
    applyStimulus(1);
    checkOutput("s3_done", {15'h0, done3}, 16'h1);
    checkOutput("s3_word", word3,          16'h8001);
    applyStimulus(1);
    checkOutput("s3_done_low", {15'h0, done3}, 16'h0);
    checkOutput("s3_busy_low", {15'h0, busy3}, 16'h0);

    // start held high: back-to-back period of 34 cycles.
    vec1   = 16'h5a5a;
    start1 = 1'b1;
    applyStimulus(1);
    applyStimulus(32);
    checkOutput("b2b_done1", {15'h0, done1}, 16'h1);
    checkOutput("b2b_word1", word1,          16'h5a5a);
    applyStimulus(1);
    checkOutput("b2b_idle", {15'h0, busy1}, 16'h0);
    applyStimulus(1);
    checkOutput("b2b_rebusy", {15'h0, busy1}, 16'h1);
    vec1 = 16'h00ff;
    applyStimulus(31);
    checkOutput("b2b_nodone", {15'h0, done1}, 16'h0);
    applyStimulus(1);
    checkOutput("b2b_done2", {15'h0, done1}, 16'h1);
    checkOutput("b2b_word2", word1,          16'h00ff);
    start1 = 1'b0;
    applyStimulus(2);
    checkOutput("b2b_stop", {15'h0, busy1}, 16'h0);

`ifdef MUX_SCAN_CONT_EN
    // Continuous scan: done pulses 33 cycles apart with no IDLE in between.
    cont1  = 1'b1;
    vec1   = 16'hffff;
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    applyStimulus(32);
    checkOutput("cont_done1", {15'h0, done1}, 16'h1);
    checkOutput("cont_word1", word1,          16'hffff);
    vec1 = 16'h0000;
    applyStimulus(1);
    checkOutput("cont_busy", {15'h0, busy1}, 16'h1);
    checkOutput("cont_sel0", {12'h0, sel1},  16'h0);
    applyStimulus(31);
    checkOutput("cont_nodone", {15'h0, done1}, 16'h0);
    applyStimulus(1);
    checkOutput("cont_done2", {15'h0, done1}, 16'h1);
    checkOutput("cont_word2", word1,          16'h0000);
    cont1 = 1'b0;
    applyStimulus(1);
    checkOutput("cont_stop", {15'h0, busy1}, 16'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
